// File: rtl/nios_system_pwm_rtos_pwm_pkg.sv
// Shared constants for the PWM peripheral: register addresses, CONTROL/STATUS
// bit positions and reset defaults.
package nios_system_pwm_rtos_pwm_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_DUTY     = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_COUNT    = 3'd5;

  localparam int unsigned CTRL_IRQ_EN  = 0;
  localparam int unsigned CTRL_RUN     = 1;
  localparam int unsigned CTRL_INVERT  = 2;

  localparam int unsigned STAT_EVENT   = 0;
  localparam int unsigned STAT_RUNNING = 1;

  localparam logic [15:0] DEF_PERIOD   = 16'd999;
  localparam logic [15:0] DEF_DUTY     = 16'd0;
  localparam logic [15:0] DEF_PRESCALE = 16'd49;

endpackage

// File: rtl/nios_system_pwm_rtos_pwm_prescaler.sv
// Run-gated reloadable down-counter; o_tick pulses for one clock each time
// the count reaches zero while running.
module nios_system_pwm_rtos_pwm_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic        i_start,
  input  logic [15:0] i_start_val,
  input  logic [15:0] i_reload_val,
  output logic        o_tick
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_start_val;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= i_reload_val;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/nios_system_pwm_rtos_pwm.sv
// Single-channel Avalon-MM PWM generator with shadowed PERIOD/DUTY/PRESCALE
// and an end-of-period interrupt.
module nios_system_pwm_rtos_pwm
  import nios_system_pwm_rtos_pwm_pkg::*;
#(
  parameter logic [15:0] RESET_PERIOD   = DEF_PERIOD,
  parameter logic [15:0] RESET_DUTY     = DEF_DUTY,
  parameter logic [15:0] RESET_PRESCALE = DEF_PRESCALE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        pwm_out
);

  logic [2:0]  r_ctrl;
  logic        r_event;
  logic [15:0] r_period_pend, r_duty_pend, r_pre_pend;
  logic [15:0] r_period_act,  r_duty_act,  r_pre_act;
  logic [15:0] r_count;
  logic        r_pwm;
  logic [15:0] r_readdata;

  logic        w_wr, w_run, w_start, w_tick, w_evt;
  logic [15:0] w_rdata;

  assign w_wr    = chipselect && !write_n;
  assign w_run   = r_ctrl[CTRL_RUN];
  assign w_start = w_wr && (address == ADDR_CONTROL) && writedata[CTRL_RUN] && !w_run;
  assign w_evt   = w_tick && (r_count == r_period_act);

  // Pending PRESCALE is the start value: actives are copied from pending on
  // the same edge that run rises, so both agree from the first running cycle.
  nios_system_pwm_rtos_pwm_prescaler u_prescaler (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_run        (w_run),
    .i_start      (w_start),
    .i_start_val  (r_pre_pend),
    .i_reload_val (r_pre_act),
    .o_tick       (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl        <= '0;
      r_period_pend <= RESET_PERIOD;
      r_duty_pend   <= RESET_DUTY;
      r_pre_pend    <= RESET_PRESCALE;
    end else if (w_wr) begin
      case (address)
        ADDR_CONTROL:  r_ctrl        <= writedata[2:0];
        ADDR_PERIOD:   r_period_pend <= writedata;
        ADDR_DUTY:     r_duty_pend   <= writedata;
        ADDR_PRESCALE: r_pre_pend    <= writedata;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period_act <= RESET_PERIOD;
      r_duty_act   <= RESET_DUTY;
      r_pre_act    <= RESET_PRESCALE;
    end else if (!w_run || w_evt) begin
      r_period_act <= r_period_pend;
      r_duty_act   <= r_duty_pend;
      r_pre_act    <= r_pre_pend;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (!w_run) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= w_evt ? '0 : r_count + 16'd1;
    end
  end

  // A clear that coincides with a new event loses, so no event is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_event <= 1'b0;
    end else if (w_evt) begin
      r_event <= 1'b1;
    end else if (w_wr && (address == ADDR_STATUS)) begin
      r_event <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (w_run && (r_count < r_duty_act)) ^ r_ctrl[CTRL_INVERT];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_STATUS: begin
        w_rdata[STAT_EVENT]   = r_event;
        w_rdata[STAT_RUNNING] = w_run;
      end
      ADDR_CONTROL:  w_rdata[2:0] = r_ctrl;
      ADDR_PERIOD:   w_rdata      = r_period_pend;
      ADDR_DUTY:     w_rdata      = r_duty_pend;
      ADDR_PRESCALE: w_rdata      = r_pre_pend;
      ADDR_COUNT:    w_rdata      = r_count;
      default:       w_rdata      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign pwm_out  = r_pwm;
  assign irq      = r_event && r_ctrl[CTRL_IRQ_EN];

endmodule

// File: doc/nios_system_pwm_rtos_pwm.md
Name: nios_system_pwm_rtos_pwm

Overview:
Avalon-MM slave PWM generator, one channel. Sits on the same Nios II data bus and clock domain as the system interval timer.
- Produces the PWM waveform that the RTOS task controls.
- Raises an end-of-period interrupt so software can update duty synchronously with the waveform.
- Register map, 16-bit data path and 1-cycle registered read mirror the timer peripheral, so the same HAL access style applies.

Parameters:
RESET_PERIOD, 999, period register reset value (waveform period = (PERIOD+1) ticks)
RESET_DUTY, 0, duty register reset value (high ticks per period)
RESET_PRESCALE, 49, prescale reset value (tick every PRESCALE+1 clocks)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  write strobe, active-low
writedata  input  16  write data
readdata  output  16  registered read data
irq  output  1  end-of-period interrupt, level
pwm_out  output  1  PWM waveform

Behaviour:
Interface:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- Write strobe = chipselect & ~write_n & address match.

Register map:
- 0 STATUS: bit0 = event (write any value clears), bit1 = running (read-only).
- 1 CONTROL[2:0]: bit0 = irq enable, bit1 = run, bit2 = invert.
- 2 PERIOD
- 3 DUTY
- 4 PRESCALE
- 5 COUNT (read-only, live counter value)
- Reads of 6–7 return 0. Writes to 0 other than the clear, and writes to 5–7, are ignored.

Read:
- readdata is registered every cycle from the address mux (chipselect not required).
- 1-cycle latency. Reset value 0.

Shadowing:
- PERIOD, DUTY and PRESCALE writes land in pending registers (readback returns the pending value).
- Active copies load from pending:
  - every cycle while run = 0;
  - at the end-of-period event while run = 1.

Prescaler:
- 16-bit down-counter.
- While run = 1: at 0, emit a 1-cycle tick and reload from active PRESCALE; otherwise decrement.
- PRESCALE = 0 gives a tick every clock.

Counter:
- 16-bit up-counter, advances only on a tick.
- If count == active PERIOD on a tick: the end-of-period event fires, count goes to 0, and actives reload in the same clock edge.
- Otherwise count increments.
- PERIOD = 0: every tick is an end-of-period event.

Output:
- pwm_out = (count < active DUTY) XOR invert, registered (1-clock delay).
- DUTY = 0 gives a constant inactive level.
- DUTY > PERIOD gives a constant active level. No wrap and no glitch in either case.

Run control:
- run 0→1: count = 0 and prescaler loads from PRESCALE in that cycle. First tick comes PRESCALE+1 clocks later.
- run = 0: count and prescaler are held at 0, pwm_out = invert, status.running = 0.

Event / irq:
- The event flag sets on the end-of-period event.
- If a STATUS write coincides with an event, set wins (no lost event).
- irq = event & irq enable (combinational from registers).

Reset values:
- pwm_out = 0, irq = 0, readdata = 0, count = 0, control = 0.
- PERIOD / DUTY / PRESCALE (pending and active) = parameter values.

Reset mid-operation: all state is forced to reset values immediately (asynchronous). Operation resumes only after software sets run.

Decomposition:
- Shared package: register address constants (ADDR_STATUS … ADDR_COUNT), CONTROL bit indices, reset-default constants.
- One natural sub-module, nios_system_pwm_rtos_pwm_prescaler: run-gated reloadable down-counter producing the tick.
- Register file, shadowing, counter/compare and irq live in the top module.

Test Plan:
- Reset, then read all registers → readdata appears 1 clock after the address; values 0, 0, 999, 0, 49, 0; pwm_out = 0, irq = 0.
- PRESCALE = 0, PERIOD = 9, DUTY = 3, CONTROL = 0x2 → pwm_out high 3 clocks, low 7 clocks, period 10 clocks, repeating; STATUS.running = 1.
- Running with PERIOD = 9; write DUTY = 7 mid-period → current period keeps 3 high; next period has 7 high; readback DUTY = 7 immediately.
- CONTROL = 0x3, PERIOD = 4, PRESCALE = 1 → irq asserts every 10 clocks at the count wrap. Writing STATUS on the same cycle as an event leaves irq = 1; writing between events drops irq.
- Boundaries: DUTY = 0 → pwm_out constantly 0; DUTY = 20 with PERIOD = 9 → constantly 1; invert = 1 → both levels flipped; PERIOD = 0 → event on every tick.
- Assert reset_n low mid-period with irq = 1 → pwm_out, irq and COUNT go to 0 asynchronously; after release, PERIOD reads 999 and the counter stays idle until run is set.
